// File: rtl/histogram_pkg.sv
// histogram_pkg: shared widths, readout FSM states and bin type for the histogram readout.
package histogram_pkg;
    localparam int HIST_ADDR_WIDTH = 8;
    localparam int HIST_DATA_WIDTH = 32;
    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_CAP, ST_OUT, ST_DONE} hist_rd_state_t;
    typedef logic [HIST_DATA_WIDTH-1:0] hist_bin_t;
endpackage

// File: rtl/histogram_readout.sv
// histogram_readout: sweeps histogram RAM port B and streams every bin out, optionally clearing it.
// Define HIST_READOUT_CDF_EN to add the saturating cumulative-sum output bin_cdf.
module histogram_readout
    import histogram_pkg::*;
#(
    parameter int ADDR_WIDTH       = HIST_ADDR_WIDTH,
    parameter int DATA_WIDTH       = HIST_DATA_WIDTH,
    parameter bit CLEAR_AFTER_READ = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic [DATA_WIDTH-1:0] b_wr_data,
    output logic                  b_wr_en,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  bin_valid,
    input  logic                  bin_ready,
    output logic [ADDR_WIDTH-1:0] bin_idx,
    output logic [DATA_WIDTH-1:0] bin_count,
    output logic                  bin_last
`ifdef HIST_READOUT_CDF_EN
    ,
    output logic [DATA_WIDTH-1:0] bin_cdf
`endif
);
    hist_rd_state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic addr_last;
    assign addr_last = addr == {ADDR_WIDTH{1'b1}};
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: state_nxt = start ? ST_RD : ST_IDLE;
            ST_RD:   state_nxt = ST_CAP;
            ST_CAP:  state_nxt = ST_OUT;
            ST_OUT:  state_nxt = bin_ready ? (addr_last ? ST_DONE : ST_RD) : ST_OUT;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            bin_idx   <= '0;
            bin_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start)
                addr <= '0;
            if (state == ST_OUT && bin_ready && !addr_last)
                addr <= addr + 1'b1;
            if (state == ST_CAP) begin
                bin_count <= b_rd_data;
                bin_idx   <= addr;
            end
        end
    end
    assign busy      = state == ST_RD || state == ST_CAP || state == ST_OUT;
    assign done      = state == ST_DONE;
    assign b_addr    = addr;
    assign b_wr_data = '0;
    assign b_wr_en   = CLEAR_AFTER_READ && state == ST_CAP;
    assign bin_valid = state == ST_OUT;
    assign bin_last  = bin_valid && addr_last;
`ifdef HIST_READOUT_CDF_EN
    // The accumulator is the output register: it already holds acc + count for the current beat.
    logic [DATA_WIDTH:0] cdf_sum;
    assign cdf_sum = {1'b0, bin_cdf} + {1'b0, b_rd_data};
    always_ff @(posedge clk) begin
        if (rst)
            bin_cdf <= '0;
        else if (state == ST_IDLE && start)
            bin_cdf <= '0;
        else if (state == ST_CAP)
            bin_cdf <= cdf_sum[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : cdf_sum[DATA_WIDTH-1:0];
    end
`endif
endmodule

// File: tb/tb_histogram_readout.sv
// tb_histogram_readout: random-ready sweeps of clearing and non-clearing readouts against a bin-level model.
module tb_histogram_readout;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NB = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic bin_ready = 1'b0;
    logic busy, done, b_wr_en, bin_valid, bin_last;
    logic k_busy, k_done, k_b_wr_en, k_bin_valid, k_bin_last;
    logic [AW-1:0] b_addr, bin_idx, k_b_addr, k_bin_idx;
    logic [DW-1:0] b_wr_data, b_rd_data, bin_count, k_b_wr_data, k_b_rd_data, k_bin_count;
`ifdef HIST_READOUT_CDF_EN
    logic [DW-1:0] bin_cdf, k_bin_cdf;
`endif
    logic a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_data = '0;
    logic [DW-1:0] mem_a [NB];
    logic [DW-1:0] mem_k [NB];
    logic [DW-1:0] exp_a [NB];
    logic [DW-1:0] exp_k [NB];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    histogram_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_AFTER_READ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .b_addr(b_addr), .b_wr_data(b_wr_data), .b_wr_en(b_wr_en), .b_rd_data(b_rd_data),
        .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_idx(bin_idx),
        .bin_count(bin_count), .bin_last(bin_last)
`ifdef HIST_READOUT_CDF_EN
        , .bin_cdf(bin_cdf)
`endif
    );

    histogram_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_AFTER_READ(1'b0)) u_keep (
        .clk(clk), .rst(rst), .start(start), .busy(k_busy), .done(k_done),
        .b_addr(k_b_addr), .b_wr_data(k_b_wr_data), .b_wr_en(k_b_wr_en), .b_rd_data(k_b_rd_data),
        .bin_valid(k_bin_valid), .bin_ready(bin_ready), .bin_idx(k_bin_idx),
        .bin_count(k_bin_count), .bin_last(k_bin_last)
`ifdef HIST_READOUT_CDF_EN
        , .bin_cdf(k_bin_cdf)
`endif
    );

    // Dual-port RAM models: port A owned by the bench, port B by each DUT (NORMAL_WRITE, 1-cycle read).
    always @(posedge clk) begin
        b_rd_data   <= mem_a[b_addr];
        k_b_rd_data <= mem_k[k_b_addr];
        if (b_wr_en) mem_a[b_addr] <= b_wr_data;
        if (k_b_wr_en) mem_k[k_b_addr] <= k_b_wr_data;
        if (a_we) begin
            mem_a[a_addr] <= a_data;
            mem_k[a_addr] <= a_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic preload(input logic [DW-1:0] base, input logic [DW-1:0] step);
        for (int i = 0; i < NB; i++) begin
            a_addr = AW'(i);
            a_data = base + step * DW'(i);
            a_we = 1'b1;
            exp_a[i] = a_data;
            exp_k[i] = a_data;
            @(negedge clk);
        end
        a_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_wr_en"}, b_wr_en, 0);
        check({tag, "_valid"}, bin_valid, 0);
        check({tag, "_last"}, bin_last, 0);
        check({tag, "_addr"}, b_addr, 0);
        check({tag, "_wr_data"}, b_wr_data, 0);
        check({tag, "_idx"}, bin_idx, 0);
        check({tag, "_count"}, bin_count, 0);
    endtask

    // One sweep; pct = bin_ready probability, poke_bin re-pulses start, rst_bin resets while presenting that bin.
    task automatic sweep(input int pct, input int poke_bin, input int rst_bin, input bit timed);
        int nxt, wr, kwr, cyc, extra, bad_a, bad_k;
        bit held, fin;
        logic [AW-1:0] h_idx;
        logic [DW-1:0] h_cnt, cur, kcur;
        logic h_last;
        longint unsigned cdf;
        logic [DW-1:0] cdf_cur;
        nxt = 0; wr = 0; kwr = 0; cyc = 0; held = 0; fin = 0; cdf = 0;
        h_idx = '0; h_cnt = '0; h_last = 0; cur = '0; kcur = '0; cdf_cur = '0;
        start = 1'b1;
        for (int t = 0; t < 6000 && !fin; t++) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) check("busy_first", busy, 1);
            if (b_wr_en) wr++;
            if (k_b_wr_en) kwr++;
            if (held) begin
                check("stall_valid", bin_valid, 1);
                check("stall_idx", bin_idx, h_idx);
                check("stall_count", bin_count, h_cnt);
                check("stall_last", bin_last, h_last);
            end else if (bin_valid) begin
                cur = exp_a[nxt];
                exp_a[nxt] = '0;
                kcur = exp_k[nxt];
                cdf = cdf + 64'(cur);
                if (cdf > 64'hFFFF_FFFF) cdf = 64'hFFFF_FFFF;
                cdf_cur = DW'(cdf);
            end
            if (done) begin
                check("done_beats", nxt, NB);
                check("done_busy", busy, 0);
                if (timed) check("done_cycle", cyc, 769);
                fin = 1;
            end
            if (rst_bin >= 0 && bin_valid && nxt == rst_bin) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                rst = 1'b0;
                check_reset_outputs("rst_mid");
                return;
            end
            bin_ready = $urandom_range(99) < pct;
            if (bin_valid && bin_ready) begin
                check("beat_idx", bin_idx, nxt);
                check("beat_count", bin_count, cur);
                check("beat_last", bin_last, nxt == NB - 1);
                check("keep_count", k_bin_count, kcur);
                check("keep_valid", k_bin_valid, 1);
`ifdef HIST_READOUT_CDF_EN
                check("beat_cdf", bin_cdf, cdf_cur);
`endif
                if (timed) check("beat_cycle", cyc, 3 + 3 * nxt);
                if (nxt == poke_bin) start = 1'b1;
                nxt++;
            end
            held = bin_valid && !bin_ready;
            h_idx = bin_idx;
            h_cnt = bin_count;
            h_last = bin_last;
        end
        if (!fin) check("sweep_timeout", 0, 1);
        check("wr_pulses", wr, NB);
        check("keep_wr_pulses", kwr, 0);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("after_done_idle", extra, 0);
        bad_a = 0;
        bad_k = 0;
        for (int i = 0; i < NB; i++) begin
            if (mem_a[i] !== exp_a[i]) bad_a++;
            if (mem_k[i] !== exp_k[i]) bad_k++;
        end
        check("ram_clear_bad_bins", bad_a, 0);
        check("ram_keep_bad_bins", bad_k, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");
        preload(32'd1000, 32'd1);
        sweep(100, -1, -1, 1'b1);
        preload(32'd1000, 32'd1);
        sweep(50, -1, -1, 1'b0);
        preload(32'd1000, 32'd1);
        sweep(100, 40, -1, 1'b1);
        preload(32'd1000, 32'd1);
        sweep(100, -1, 100, 1'b0);
        sweep(60, -1, -1, 1'b0);
`ifdef HIST_READOUT_CDF_EN
        preload(32'h0100_0000, 32'd0);
        sweep(100, -1, -1, 1'b1);
        preload(32'h0100_0000, 32'd0);
        sweep(50, -1, -1, 1'b0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
